// File: rtl/XT_LBUS_Pkg.sv
// Local-bus slave view and the keypad register map shared by the keypad blocks.
package XT_LBUS_Pkg;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] wdata;
  } lb_slave_t;

  localparam logic [1:0] KEY_REG_STATE   = 2'd0;
  localparam logic [1:0] KEY_REG_PRESS   = 2'd1;
  localparam logic [1:0] KEY_REG_IRQEN   = 2'd2;
  localparam logic [1:0] KEY_REG_RELEASE = 2'd3;

  localparam int KEY_CNT_W = 16;

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchronizer, saturating stability counter and debounced state.
module key_debounce
  import XT_LBUS_Pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic state_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic                 INV   = (ACTIVE_LOW != 0);
  localparam logic [KEY_CNT_W-1:0] LIMIT = KEY_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [KEY_CNT_W-1:0] ONE   = KEY_CNT_W'(1);

  logic                 sync1_q, sync2_q;
  logic                 state_q, state_d;
  logic [KEY_CNT_W-1:0] cnt_q, cnt_d;
  logic                 flip;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    flip    = 1'b0;
    if (sync2_q == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == LIMIT) begin
      flip    = 1'b1;
      state_d = ~state_q;
      cnt_d   = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Inverting ahead of the synchronizer makes a cleared synchronizer mean "released".
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_i ^ INV;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;
  assign rise_o  = flip & ~state_q;
  assign fall_o  = flip & state_q;

endmodule

// File: rtl/key_debounce_lbus.sv
// Debounced keypad with local-bus registers and level interrupt.
// Define KEY_RELEASE_EVENT_EN to add release events at address 3.
module key_debounce_lbus
  import XT_LBUS_Pkg::*;
#(
  parameter int NUM             = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic           lb_clk,
  input  logic           rst_n,
  input  lb_slave_t      xt_lb,
  input  logic           wsel,
  output logic [7:0]     rdata,
  input  logic [NUM-1:0] key_in,
  output logic           irq
);

  logic [NUM-1:0] keyState, keyRise, keyFall;
  logic [NUM-1:0] pressEvt_q, pressEvt_d;
  logic [NUM-1:0] irqEn_q, irqEn_d;
  logic [NUM-1:0] releaseView;
  logic [NUM-1:0] wKeys;
  logic           irq_q, irq_d;
  logic           wrPress, wrIrqEn;
  logic [13:0]    unusedLb;

  for (genvar g = 0; g < NUM; g++) begin : genKey
    key_debounce #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) keyInst (
      .clk_i   (lb_clk),
      .rst_ni  (rst_n),
      .key_i   (key_in[g]),
      .state_o (keyState[g]),
      .rise_o  (keyRise[g]),
      .fall_o  (keyFall[g])
    );
  end

  assign wKeys    = xt_lb.wdata[NUM-1:0];
  assign wrPress  = wsel && (xt_lb.addr[1:0] == KEY_REG_PRESS);
  assign wrIrqEn  = wsel && (xt_lb.addr[1:0] == KEY_REG_IRQEN);
  assign unusedLb = {xt_lb.addr[7:2], xt_lb.wdata};

`ifdef KEY_RELEASE_EVENT_EN
  logic [NUM-1:0] releaseEvt_q, releaseEvt_d;
  logic           wrRelease;

  assign wrRelease = wsel && (xt_lb.addr[1:0] == KEY_REG_RELEASE);

  always_comb begin
    releaseEvt_d = (releaseEvt_q & ~(wrRelease ? wKeys : '0)) | keyFall;
  end

  always_ff @(posedge lb_clk) begin
    if (!rst_n) releaseEvt_q <= '0;
    else        releaseEvt_q <= releaseEvt_d;
  end

  assign releaseView = releaseEvt_q;
`else
  logic [NUM-1:0] unusedFall;
  assign unusedFall  = keyFall;
  assign releaseView = '0;
`endif

  // A new event wins over a simultaneous write-1-to-clear of the same bit.
  always_comb begin
    pressEvt_d = (pressEvt_q & ~(wrPress ? wKeys : '0)) | keyRise;
    irqEn_d    = wrIrqEn ? wKeys : irqEn_q;
    irq_d      = |((pressEvt_q | releaseView) & irqEn_q);
  end

  always_ff @(posedge lb_clk) begin
    if (!rst_n) begin
      pressEvt_q <= '0;
      irqEn_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      pressEvt_q <= pressEvt_d;
      irqEn_q    <= irqEn_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (xt_lb.addr[1:0])
      KEY_REG_STATE:   rdata[NUM-1:0] = keyState;
      KEY_REG_PRESS:   rdata[NUM-1:0] = pressEvt_q;
      KEY_REG_IRQEN:   rdata[NUM-1:0] = irqEn_q;
      KEY_REG_RELEASE: rdata[NUM-1:0] = releaseView;
      default:         rdata = '0;
    endcase
  end

  assign irq = irq_q;

endmodule
